// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the burst-refill instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    REFILL,
    RESPOND
  } state_e;

  function automatic int calc_ob(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  function automatic int calc_wb(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int calc_ib(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int calc_tw(input int addr_w, input int word_w,
                                 input int line_words, input int lines);
    return addr_w - calc_ob(word_w) - calc_wb(line_words) - calc_ib(lines);
  endfunction

endpackage

// File: rtl/icache_ram.sv
// Single-port RAM, synchronous read, write-enable; read returns the pre-write contents.
module icache_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_burst.sv
// Direct-mapped instruction cache with critical-word-first burst refill and invalidate walk.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_burst
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [WORD_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              inv,
  output logic              busy,
`ifdef ICACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data
);

  localparam int OB     = calc_ob(WORD_W);
  localparam int WB     = calc_wb(LINE_WORDS);
  localparam int IB     = calc_ib(LINES);
  localparam int TW     = calc_tw(ADDR_W, WORD_W, LINE_WORDS, LINES);
  localparam int IDX_LO = OB + WB;
  localparam int TAG_LO = OB + WB + IB;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OB) - 1);

  state_e              state_q, state_d;
  logic [IB-1:0]       init_q, init_d;
  logic [WB-1:0]       cnt_q, cnt_d;
  logic                inv_q, inv_d;
  logic [ADDR_W-1:0]   req_q, req_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [LINES-1:0]    valid_q, valid_d;

  logic                dram_we, tram_we;
  logic [IB+WB-1:0]    dram_addr;
  logic [IB-1:0]       tram_addr;
  logic [WORD_W-1:0]   dram_rdata;
  logic [TW-1:0]       tram_rdata;
  logic                lookup_hit;

  logic [WB-1:0] req_sel, maddr_sel;
  logic [IB-1:0] req_idx;
  logic [TW-1:0] req_tag;

  assign req_sel    = req_q[IDX_LO-1:OB];
  assign req_idx    = req_q[TAG_LO-1:IDX_LO];
  assign req_tag    = req_q[ADDR_W-1:TAG_LO];
  assign maddr_sel  = maddr_q[IDX_LO-1:OB];
  assign lookup_hit = valid_q[req_idx] && (tram_rdata == req_tag);

  icache_ram #(.DEPTH(LINES * LINE_WORDS), .WIDTH(WORD_W)) u_data_ram (
    .clk     (clk),
    .we_i    (dram_we),
    .addr_i  (dram_addr),
    .wdata_i (mem_data),
    .rdata_o (dram_rdata)
  );

  icache_ram #(.DEPTH(LINES), .WIDTH(TW)) u_tag_ram (
    .clk     (clk),
    .we_i    (tram_we),
    .addr_i  (tram_addr),
    .wdata_i (req_tag),
    .rdata_o (tram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= INIT;
      init_q   <= '0;
      cnt_q    <= '0;
      inv_q    <= 1'b0;
      req_q    <= '0;
      data_q   <= '0;
      mem_en_q <= 1'b0;
      maddr_q  <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
      req_q    <= req_d;
      data_q   <= data_d;
      mem_en_q <= mem_en_d;
      maddr_q  <= maddr_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    req_d     = req_q;
    data_d    = data_q;
    mem_en_d  = mem_en_q;
    maddr_d   = maddr_q;
    valid_d   = valid_q;
    dram_we   = 1'b0;
    tram_we   = 1'b0;
    dram_addr = cpu_addr[TAG_LO-1:OB];
    tram_addr = cpu_addr[TAG_LO-1:IDX_LO];

    // An invalidate seen anywhere but IDLE waits in inv_q for the next IDLE.
    if (state_q != IDLE && inv) inv_d = 1'b1;

    case (state_q)
      INIT: begin
        valid_d[init_q] = 1'b0;
        init_d          = init_q + IB'(1);
        if (init_q == IB'(LINES - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (inv || inv_q) begin
          inv_d   = 1'b0;
          init_d  = '0;
          state_d = INIT;
        end else if (cpu_en) begin
          req_d   = cpu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          data_d  = dram_rdata;
          state_d = RESPOND;
        end else begin
          mem_en_d = 1'b1;
          maddr_d  = req_q & ~OFF_MASK;
          cnt_d    = '0;
          state_d  = REFILL;
        end
      end
      REFILL: begin
        dram_addr = {req_idx, maddr_sel};
        tram_addr = req_idx;
        if (mem_ack) begin
          dram_we                = 1'b1;
          maddr_d[IDX_LO-1:OB]   = maddr_sel + WB'(1);
          cnt_d                  = cnt_q + WB'(1);
          if (maddr_sel == req_sel) data_d = mem_data;
          if (cnt_q == WB'(LINE_WORDS - 1)) begin
            tram_we          = 1'b1;
            valid_d[req_idx] = 1'b1;
            mem_en_d         = 1'b0;
            state_d          = RESPOND;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  assign cpu_ack  = (state_q == RESPOND);
  assign busy     = (state_q == INIT);
  assign cpu_data = data_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = maddr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (lookup_hit) hit_q <= hit_q + 32'd1;
      else            miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
`endif

endmodule

// File: tb/tb_icache_burst.sv
// Bench for icache_burst: fetch table with scoreboard, burst-order checks and refill/inv/reset corner sequences.
module tb_icache_burst;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_en = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_data;
  logic        cpu_ack;
  logic        inv = 1'b0;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_burst dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ack    (cpu_ack),
    .inv        (inv),
    .busy       (busy),
`ifdef ICACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb_q[$];
  logic [15:0] addr_log[$];
  int          stall_pct = 25;
  bit          hold_ack = 0;
  bit          spurious = 0;
  int          ack_budget = -1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A3C, a};
  endfunction

  function automatic logic [15:0] burst_addr(input logic [15:0] a, input int i);
    logic [1:0] s;
    s = a[3:2] + 2'(i);
    return {a[15:4], s, 2'b00};
  endfunction

  // Memory model: drives one cycle of response just after each rising edge.
  logic        prev_en = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;
  always begin
    @(posedge clk);
    #1;
    if (mem_en && prev_en && !prev_ack) chk("mem_addr_hold", {16'h0, mem_addr}, {16'h0, prev_addr});
    prev_en   = mem_en;
    prev_addr = mem_addr;
    if (mem_en && !hold_ack && ack_budget != 0 && $urandom_range(0, 99) >= stall_pct) begin
      mem_ack  = 1'b1;
      mem_data = mem_word(mem_addr);
      addr_log.push_back(mem_addr);
      if (ack_budget > 0) ack_budget--;
    end else if (!mem_en && spurious && $urandom_range(0, 3) == 0) begin
      mem_ack  = 1'b1;
      mem_data = 32'hDEAD_BEEF;
    end else begin
      mem_ack  = 1'b0;
      mem_data = '0;
    end
    prev_ack = mem_ack && mem_en;
  end

  // Scoreboard: every cpu_ack consumes exactly one expected word.
  always @(negedge clk) begin
    if (cpu_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        chk("cpu_data", cpu_data, sb_q.pop_front());
      end
    end
  end

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    int n;
    reset  = 1'b0;
    cpu_en = 1'b0;
    inv    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ack", {31'h0, cpu_ack}, 32'd0);
    chk("rst_cpu_data", cpu_data, 32'd0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'd0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    count_busy(n);
    chk("init_len", n, 256);
  endtask

  task automatic fetch(input logic [15:0] a, input bit exp_miss);
    int   lat, first_en;
    bit   got, last_ack;
    addr_log.delete();
    @(negedge clk);
    cpu_en   = 1'b1;
    cpu_addr = a;
    sb_q.push_back(mem_word(a & 16'hFFFC));
    lat = 0; first_en = -1; got = 0; last_ack = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (cpu_ack === 1'b1) begin
        got = 1;
        break;
      end
      if (mem_en === 1'b1 && first_en < 0) first_en = lat;
      last_ack = (mem_ack && mem_en === 1'b1);
    end
    cpu_en = 1'b0;
    chk("ack_seen", {31'h0, got}, 32'd1);
    if (exp_miss) begin
      chk("miss_mem_en_rise", first_en, 2);
      chk("ack_after_last_mem_ack", {31'h0, last_ack}, 32'd1);
      chk("burst_len", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
        chk("burst_addr", {16'h0, addr_log[i]}, {16'h0, burst_addr(a, i)});
    end else begin
      chk("hit_latency", lat, 2);
      chk("hit_no_mem_en", first_en, -1);
      chk("hit_burst_len", addr_log.size(), 0);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    bit          miss;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n, ack1, ack2;
    bit got;

    vecs[0]  = '{16'h0104, 1'b1};
    vecs[1]  = '{16'h0108, 1'b0};
    vecs[2]  = '{16'h010C, 1'b0};
    vecs[3]  = '{16'h1100, 1'b1};
    vecs[4]  = '{16'h0104, 1'b1};
    vecs[5]  = '{16'h0100, 1'b0};
    vecs[6]  = '{16'h1104, 1'b1};
    vecs[7]  = '{16'h0200, 1'b1};
    vecs[8]  = '{16'h020C, 1'b0};
    vecs[9]  = '{16'h1108, 1'b0};
    vecs[10] = '{16'hFFFC, 1'b1};
    vecs[11] = '{16'hFFF0, 1'b0};
    vecs[12] = '{16'h0FF4, 1'b1};
    vecs[13] = '{16'h0006, 1'b1};
    vecs[14] = '{16'h0001, 1'b0};

    do_reset();

    spurious = 1;
    foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].miss);
    spurious = 0;

    // cpu_en held high across RESPOND: second hit must start only after IDLE.
    @(negedge clk);
    cpu_en   = 1'b1;
    cpu_addr = 16'h0008;
    sb_q.push_back(mem_word(16'h0008));
    sb_q.push_back(mem_word(16'h0008));
    ack1 = -1; ack2 = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        if (ack1 < 0) ack1 = i;
        else begin
          ack2 = i;
          break;
        end
      end
    end
    cpu_en = 1'b0;
    chk("b2b_ack1", ack1, 2);
    chk("b2b_ack2", ack2, 5);

    // Invalidate during a stalled refill.
    addr_log.delete();
    hold_ack = 1;
    @(negedge clk);
    cpu_en   = 1'b1;
    cpu_addr = 16'h0300;
    sb_q.push_back(mem_word(16'h0300));
    for (int i = 0; i < 20 && mem_en !== 1'b1; i++) @(negedge clk);
    chk("inv_refill_mem_en", {31'h0, mem_en}, 32'd1);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    repeat (3) @(negedge clk);
    chk("inv_stall_busy", {31'h0, busy}, 32'd0);
    chk("inv_stall_mem_en", {31'h0, mem_en}, 32'd1);
    hold_ack = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        got = 1;
        break;
      end
    end
    cpu_en = 1'b0;
    chk("inv_refill_ack", {31'h0, got}, 32'd1);
    chk("inv_refill_burst_len", addr_log.size(), 4);
    n = 0;
    @(negedge clk);
    while (busy !== 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("inv_idle_gap", n, 1);
    count_busy(n);
    chk("inv_walk_len", n, 256);
    fetch(16'h1100, 1'b1);
    fetch(16'h0300, 1'b1);

    // Reset after two of four refill acks.
    addr_log.delete();
    ack_budget = 2;
    @(negedge clk);
    cpu_en   = 1'b1;
    cpu_addr = 16'h0104;
    for (int i = 0; i < 300 && addr_log.size() < 2; i++) @(negedge clk);
    chk("rst_mid_two_acks", addr_log.size(), 2);
    @(negedge clk);
    reset  = 1'b0;
    cpu_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_en", {31'h0, mem_en}, 32'd0);
    chk("rst_mid_mem_addr", {16'h0, mem_addr}, 32'd0);
    chk("rst_mid_busy", {31'h0, busy}, 32'd1);
    reset      = 1'b1;
    ack_budget = -1;
    count_busy(n);
    chk("rst_mid_init_len", n, 256);
    fetch(16'h0104, 1'b1);

    // Statistics sequence, then an invalidate issued from IDLE.
    do_reset();
    fetch(16'h0104, 1'b1);
    fetch(16'h0108, 1'b0);
    fetch(16'h010C, 1'b0);
    fetch(16'h1100, 1'b1);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'd2);
    chk("miss_count", miss_count, 32'd2);
`endif
    @(negedge clk);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    count_busy(n);
    chk("inv_idle_walk_len", n, 256);
`ifdef ICACHE_STATS_EN
    chk("hit_count_after_inv", hit_count, 32'd2);
    chk("miss_count_after_inv", miss_count, 32'd2);
`endif
    fetch(16'h1100, 1'b1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
